// File: rtl/vector_cmd_queue.sv
// Command FIFO plus serial issue sequencer for the vector processing unit.
// One command is outstanding at a time; a watchdog guards against a hung VPU.
module vector_cmd_queue #(
  parameter int CMD_W   = 128,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CMD_W-1:0]         in_cmd,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CMD_W-1:0]         vpu_cmd,
  output logic                     vpu_cmd_valid,
  input  logic                     vpu_cmd_ready,
  input  logic                     vpu_cmd_done,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     retire,
  output logic [15:0]              done_count,
  output logic                     timeout_err,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [TW-1:0]    wd_cnt;

  logic push;
  logic load;
  logic issue_hs;

  // Both handshakes are strict valid/ready: a transfer happens on a rising
  // clk edge where valid and ready are both high; once raised, valid holds
  // its payload stable until that edge.
  assign in_ready = (count != FULL_LVL) && !flush;
  assign push     = in_valid && in_ready;
  // The presented command is held in vpu_cmd, so its slot is released when it
  // is copied out; level therefore never counts the presented command.
  assign load     = (state == IDLE) && (count != '0) && !flush;
  assign issue_hs = (state == ISSUE) && vpu_cmd_valid && vpu_cmd_ready;

  assign level     = count;
  assign busy      = (state != IDLE) || (count != '0);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, load})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      vpu_cmd       <= '0;
      vpu_cmd_valid <= 1'b0;
      wd_cnt        <= '0;
      retire        <= 1'b0;
      done_count    <= '0;
      timeout_err   <= 1'b0;
    end else begin
      retire <= 1'b0;
      if (flush) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            vpu_cmd       <= mem[rd_ptr];
            vpu_cmd_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_hs) begin
            vpu_cmd_valid <= 1'b0;
            wd_cnt        <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (vpu_cmd_done) begin
            retire     <= 1'b1;
            done_count <= done_count + 16'd1;
            state      <= IDLE;
          end else if (wd_cnt == WD_LAST) begin
            // A flush in the same cycle keeps the flag clear.
            if (!flush) timeout_err <= 1'b1;
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + TW'(1);
          end
        end
        default: begin
          vpu_cmd_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_cmd_queue.sv
// Directed bench for vector_cmd_queue: a stimulus table for fill/drain plus
// hand-written sequences for backpressure, flush, watchdog, reset and wrap.
module tb_vector_cmd_queue;

  localparam int W = 128;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  in_cmd;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  vpu_cmd;
  logic          vpu_cmd_valid;
  logic          vpu_cmd_ready;
  logic          vpu_cmd_done;
  logic          flush;
  logic [2:0]    level;
  logic          busy;
  logic          retire;
  logic [15:0]   done_count;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  vector_cmd_queue #(.CMD_W(W), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_cmd(in_cmd), .in_valid(in_valid),
    .in_ready(in_ready), .vpu_cmd(vpu_cmd), .vpu_cmd_valid(vpu_cmd_valid),
    .vpu_cmd_ready(vpu_cmd_ready), .vpu_cmd_done(vpu_cmd_done), .flush(flush),
    .level(level), .busy(busy), .retire(retire), .done_count(done_count),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_q[$];
  int ret_cnt = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_order(input string nm);
    chk({nm, "_count"}, W'(acc_q.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk($sformatf("%s_%0d", nm, i), acc_q[i], exp_q[i]);
  endtask

  // VPU model: logs accepted commands, counts retire pulses, and answers
  // each accept with a done pulse lat cycles later when vpu_auto is set.
  int  lat = 3;
  bit  vpu_auto = 1'b1;
  bit  force_done = 1'b0;
  int  vcnt = 0;

  initial begin
    logic hs;
    vpu_cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      hs = vpu_cmd_valid && vpu_cmd_ready && rst_n;
      if (hs) acc_q.push_back(vpu_cmd);
      if (retire) ret_cnt++;
      @(posedge clk);
      #1;
      vpu_cmd_done = 1'b0;
      if (!rst_n) vcnt = 0;
      if (hs) vcnt = lat;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) vpu_cmd_done = vpu_auto;
      end
      if (force_done) begin
        vpu_cmd_done = 1'b1;
        force_done = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_dc(input logic [15:0] target, input int budget, input string nm);
    int n = 0;
    while (done_count !== target && n < budget) begin
      cyc();
      n++;
    end
    chk(nm, W'(done_count), W'(target));
  endtask

  function automatic logic [W-1:0] mk_cmd(input logic [7:0] op, input logic [7:0] sub, input int n);
    return {op, sub, 112'(n)};
  endfunction

  typedef struct {
    logic         iv;
    logic [W-1:0] cmd;
    logic         rdy;
    logic         ev;
    logic [W-1:0] ecmd;
    logic [2:0]   elvl;
    logic         eir;
    logic         eret;
  } vec_t;

  vec_t tbl[11];
  logic [W-1:0] c[7];
  logic [W-1:0] add_cmd;
  logic [15:0]  dc0;
  int           r0;

  initial begin
    for (int i = 0; i < 7; i++) c[i] = mk_cmd(8'h02 + 8'(i), 8'h10, 100 + i);
    add_cmd = {8'h01, 8'h10, 112'd1};
    tbl[0]  = '{1'b1, c[1], 1'b0, 1'b0, '0,   3'd1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, c[2], 1'b0, 1'b1, c[1], 3'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, c[3], 1'b0, 1'b1, c[1], 3'd2, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, c[4], 1'b0, 1'b1, c[1], 3'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, c[5], 1'b0, 1'b1, c[1], 3'd4, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, c[6], 1'b0, 1'b1, c[1], 3'd4, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, '0,   1'b1, 1'b0, '0,   3'd4, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, '0,   1'b1, 1'b0, '0,   3'd4, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, '0,   1'b1, 1'b0, '0,   3'd4, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, '0,   1'b1, 1'b1, c[2], 3'd3, 1'b1, 1'b0};
    tbl[10] = '{1'b0, '0,   1'b1, 1'b0, '0,   3'd3, 1'b1, 1'b0};

    rst_n = 1'b0; in_cmd = '0; in_valid = 1'b0; vpu_cmd_ready = 1'b0; flush = 1'b0;
    #12;
    chk("rst_vpu_cmd", vpu_cmd, '0);
    chk("rst_valid", W'(vpu_cmd_valid), '0);
    chk("rst_level", W'(level), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_retire", W'(retire), '0);
    chk("rst_done_count", W'(done_count), '0);
    chk("rst_timeout_err", W'(timeout_err), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    cyc();
    rst_n = 1'b1;
    cyc();

    // single command, done 3 cycles after accept
    lat = 3; vpu_cmd_ready = 1'b1; acc_q.delete();
    in_valid = 1'b1; in_cmd = add_cmd;
    cyc();
    chk("single_e0_valid", W'(vpu_cmd_valid), '0);
    chk("single_e0_level", W'(level), W'(1));
    chk("single_e0_busy", W'(busy), W'(1));
    in_valid = 1'b0;
    cyc();
    chk("single_e1_valid", W'(vpu_cmd_valid), W'(1));
    chk("single_e1_cmd", vpu_cmd, add_cmd);
    chk("single_e1_level", W'(level), '0);
    cyc();
    chk("single_e2_valid", W'(vpu_cmd_valid), '0);
    cyc();
    cyc();
    chk("single_e4_retire", W'(retire), '0);
    cyc();
    chk("single_e5_retire", W'(retire), W'(1));
    chk("single_e5_count", W'(done_count), W'(1));
    chk("single_e5_busy", W'(busy), '0);
    cyc();
    chk("single_e6_retire", W'(retire), '0);
    exp_q = '{add_cmd};
    chk_order("single_order");

    // fill and drain from the table
    lat = 2; acc_q.delete();
    for (int i = 0; i < 11; i++) begin
      in_valid = tbl[i].iv; in_cmd = tbl[i].cmd; vpu_cmd_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("tbl%0d_valid", i), W'(vpu_cmd_valid), W'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_cmd", i), vpu_cmd, tbl[i].ecmd);
      chk($sformatf("tbl%0d_level", i), W'(level), W'(tbl[i].elvl));
      chk($sformatf("tbl%0d_in_ready", i), W'(in_ready), W'(tbl[i].eir));
      chk($sformatf("tbl%0d_retire", i), W'(retire), W'(tbl[i].eret));
    end
    in_valid = 1'b0;
    wait_dc(16'd6, 100, "fill_done_count");
    cyc();
    chk("fill_level", W'(level), '0);
    chk("fill_busy", W'(busy), '0);
    exp_q = '{c[1], c[2], c[3], c[4], c[5]};
    chk_order("fill_order");

    // backpressure: ready low for 10 cycles while in ISSUE
    vpu_cmd_ready = 1'b0; acc_q.delete();
    in_valid = 1'b1; in_cmd = c[3];
    cyc();
    in_cmd = c[4];
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("bp%0d_valid", i), W'(vpu_cmd_valid), W'(1));
      chk($sformatf("bp%0d_cmd", i), vpu_cmd, c[3]);
      chk($sformatf("bp%0d_level", i), W'(level), W'(1));
    end
    vpu_cmd_ready = 1'b1;
    cyc();
    chk("bp_hs_valid", W'(vpu_cmd_valid), '0);
    chk("bp_hs_level", W'(level), W'(1));
    wait_dc(16'd8, 60, "bp_done_count");
    exp_q = '{c[3], c[4]};
    chk_order("bp_order");

    // flush with 3 queued and one in WAIT
    lat = 8; cyc(); acc_q.delete(); dc0 = done_count; r0 = ret_cnt;
    in_valid = 1'b1; in_cmd = c[0]; cyc();
    in_cmd = c[1]; cyc();
    in_cmd = c[2]; cyc();
    in_cmd = c[5]; cyc();
    in_valid = 1'b0;
    chk("fl_level_before", W'(level), W'(3));
    flush = 1'b1;
    #1;
    chk("fl_in_ready", W'(in_ready), '0);
    cyc();
    chk("fl_level_after", W'(level), '0);
    flush = 1'b0;
    repeat (14) cyc();
    chk("fl_done_count", W'(done_count), W'(dc0 + 16'd1));
    chk("fl_retires", W'(ret_cnt - r0), W'(1));
    chk("fl_busy", W'(busy), '0);
    exp_q = '{c[0]};
    chk_order("fl_order");

    // watchdog, TIMEOUT=16, no done from the VPU
    vpu_auto = 1'b0; acc_q.delete(); dc0 = done_count;
    in_valid = 1'b1; in_cmd = c[2]; cyc();
    in_cmd = c[6]; cyc();
    in_valid = 1'b0; cyc();
    repeat (15) cyc();
    chk("wd_h15_err", W'(timeout_err), '0);
    force_done = 1'b1;
    cyc();
    chk("wd_h16_err", W'(timeout_err), W'(1));
    chk("wd_h16_state", W'(dbg_state), '0);
    chk("wd_h16_level", W'(level), W'(1));
    cyc();
    chk("wd_next_valid", W'(vpu_cmd_valid), W'(1));
    chk("wd_next_cmd", vpu_cmd, c[6]);
    chk("wd_late_retire", W'(retire), '0);
    cyc();
    chk("wd_late_count", W'(done_count), W'(dc0));
    chk("wd_late_retire2", W'(retire), '0);
    chk("wd_err_sticky", W'(timeout_err), W'(1));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("wd_flush_clears", W'(timeout_err), '0);
    repeat (14) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("wd_flush_wins_err", W'(timeout_err), '0);
    chk("wd_flush_wins_state", W'(dbg_state), '0);
    chk("wd_flush_wins_busy", W'(busy), '0);
    cyc();
    chk("wd_flush_wins_err2", W'(timeout_err), '0);
    exp_q = '{c[2], c[6]};
    chk_order("wd_order");

    // asynchronous reset while a command is in WAIT
    in_valid = 1'b1; in_cmd = c[4]; cyc();
    in_valid = 1'b0; cyc();
    cyc();
    chk("rw_state_wait", W'(dbg_state), W'(2));
    r0 = ret_cnt;
    rst_n = 1'b0;
    #1;
    chk("rw_vpu_cmd", vpu_cmd, '0);
    chk("rw_valid", W'(vpu_cmd_valid), '0);
    chk("rw_level", W'(level), '0);
    chk("rw_busy", W'(busy), '0);
    chk("rw_done_count", W'(done_count), '0);
    chk("rw_in_ready", W'(in_ready), W'(1));
    cyc();
    cyc();
    rst_n = 1'b1;
    vpu_auto = 1'b1;
    repeat (20) cyc();
    chk("rw_no_retire", W'(ret_cnt - r0), '0);
    chk("rw_state_idle", W'(dbg_state), '0);

    // done_count wrap from 0xFFFF
    lat = 1;
    force dut.done_count = 16'hFFFF;
    cyc();
    release dut.done_count;
    cyc();
    chk("wrap_preload", W'(done_count), W'(16'hFFFF));
    in_valid = 1'b1; in_cmd = c[5]; cyc();
    in_valid = 1'b0;
    wait_dc(16'h0000, 40, "wrap_done_count");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
